sys_feeder: RTL and testbench

SYS_FEEDER -- requirements
Module: sys_feeder

---
 rtl/sys_feeder_if.sv | 24 ++
 rtl/sys_feeder.sv | 127 ++++++++++++
 tb/tb_sys_feeder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_feeder_if.sv
// Handshake bundle between the source/controller side and the systolic-array feeder.
interface sys_feeder_if #(
    parameter int DW = 8
);
    logic          start;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          w_ps;
    logic [DW-1:0] arr_data;
    logic          arr_valid;
    logic          busy;
    logic          done;

    modport master (
        output start, src_valid, src_data,
        input  src_ready, w_ps, arr_data, arr_valid, busy, done
    );

    modport slave (
        input  start, src_valid, src_data,
        output src_ready, w_ps, arr_data, arr_valid, busy, done
    );
endinterface

// File: rtl/sys_feeder.sv
// Systolic-array feeder: streams NW weight words, one idle gap cycle, then NP
// partial-sum words from a valid/ready source, with registered array outputs.
//
// state  | meaning
// IDLE   | waiting for start, source not accepted
// LOAD_W | weight words accepted, w_ps high
// GAP    | single dead cycle separating weight and psum phases
// LOAD_P | partial-sum words accepted
// DONE   | one-cycle done pulse, then back to IDLE
module sys_feeder #(
    parameter int DW = 8,
    parameter int NW = 32,
    parameter int NP = 16
) (
    input  logic       clk,
    input  logic       rst,
    sys_feeder_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] LOAD_P = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Counter only ever reaches NW-1 / NP-1 before being cleared, so it never wraps.
    localparam logic [7:0] W_LAST = 8'(NW - 1);
    localparam logic [7:0] P_LAST = 8'(NP - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic          src_ready;
    logic          xfer;
    logic          w_ps_q;
    logic          arr_valid_q;
    logic [DW-1:0] arr_data_q;

    // Ready depends on state alone so the source never sees a combinational loop.
    assign src_ready = (state == LOAD_W) || (state == LOAD_P);
    assign xfer      = bus.src_valid && src_ready;

    // Next-state and word-counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_W;
                    cnt_nxt   = 8'd0;
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    if (cnt == W_LAST) begin
                        state_nxt = GAP;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                state_nxt = LOAD_P;
            end
            LOAD_P: begin
                if (xfer) begin
                    if (cnt == P_LAST) begin
                        state_nxt = DONE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and word counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // w_ps is a flop so the array controller sees a glitch-free phase flag;
    // the last weight word therefore lands on arr_data during GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ps_q <= 1'b0;
        end else begin
            w_ps_q <= (state_nxt == LOAD_W);
        end
    end

    // Registered array port: valid for exactly one cycle per transfer, data held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_valid_q <= 1'b0;
            arr_data_q  <= '0;
        end else begin
            arr_valid_q <= xfer;
            if (xfer) begin
                arr_data_q <= bus.src_data;
            end
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.w_ps      = w_ps_q;
    assign bus.arr_valid = arr_valid_q;
    assign bus.arr_data  = arr_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_sys_feeder.sv
// Randomized self-checking bench for sys_feeder against a phase/word-count model.
module tb_sys_feeder;
    localparam int DW = 8;
    localparam int NW = 32;
    localparam int NP = 16;

    localparam int PH_IDLE = 0;
    localparam int PH_W    = 1;
    localparam int PH_GAP  = 2;
    localparam int PH_P    = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sys_feeder_if #(.DW(DW)) bus_a ();
    sys_feeder_if #(.DW(DW)) bus_b ();

    sys_feeder #(.DW(DW), .NW(NW), .NP(NP)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sys_feeder #(.DW(DW), .NW(1),  .NP(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // Model: which phase we are in and how many words of that phase have moved.
    int         m_phase;
    int         m_cnt;
    logic       m_av;
    logic [7:0] m_ad;

    // Trace bits: {w_ps, src_ready, arr_valid, busy, done, arr_data[7:0]}
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    logic [7:0]  sent_q[$];
    logic [7:0]  rcv_q[$];

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_cnt   = 0;
        m_av    = 1'b0;
        m_ad    = 8'h00;
    endtask

    task automatic clear_trace();
        exp_q.delete();
        obs_q.delete();
        sent_q.delete();
        rcv_q.delete();
    endtask

    task automatic collect_rcv();
        rcv_q.delete();
        foreach (obs_q[i]) if (obs_q[i][10]) rcv_q.push_back(obs_q[i][7:0]);
    endtask

    // One clock of dut_a: record observed vs predicted outputs, drive, advance model.
    task automatic drive_cycle(input logic st, input logic sv, input logic [7:0] sd);
        logic ready;
        logic xfer;
        ready = (m_phase == PH_W) || (m_phase == PH_P);
        exp_q.push_back({(m_phase == PH_W), ready, m_av, (m_phase != PH_IDLE),
                         (m_phase == PH_DONE), m_ad});
        obs_q.push_back({bus_a.w_ps, bus_a.src_ready, bus_a.arr_valid, bus_a.busy,
                         bus_a.done, bus_a.arr_data});
        bus_a.start     = st;
        bus_a.src_valid = sv;
        bus_a.src_data  = sd;
        xfer = sv && ready;
        m_av = xfer;
        if (xfer) begin
            m_ad = sd;
            sent_q.push_back(sd);
        end
        case (m_phase)
            PH_IDLE: if (st) begin m_phase = PH_W; m_cnt = 0; end
            PH_W:    if (xfer) begin
                         m_cnt++;
                         if (m_cnt == NW) begin m_phase = PH_GAP; m_cnt = 0; end
                     end
            PH_GAP:  m_phase = PH_P;
            PH_P:    if (xfer) begin
                         m_cnt++;
                         if (m_cnt == NP) begin m_phase = PH_DONE; m_cnt = 0; end
                     end
            default: m_phase = PH_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_a.start = 1'b0; bus_a.src_valid = 1'b0; bus_a.src_data = 8'h00;
        bus_b.start = 1'b0; bus_b.src_valid = 1'b0; bus_b.src_data = 8'h00;
        model_reset();
        #1;
        checks++;
        if ({bus_a.w_ps, bus_a.src_ready, bus_a.arr_valid, bus_a.busy, bus_a.done, bus_a.arr_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {bus_a.w_ps, bus_a.src_ready, bus_a.arr_valid, bus_a.busy, bus_a.done, bus_a.arr_data});
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        clear_trace();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_full_stream();
        int wps_n;
        int av_n;
        int busy_n;
        int done_at;
        int done_n;
        clear_trace();
        for (int i = 0; i < 60; i++) drive_cycle(i == 0, 1'b1, 8'(m_cnt));
        wps_n = 0; av_n = 0; busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_trace cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][12]) wps_n++;
            if (obs_q[i][10]) av_n++;
            if (obs_q[i][9])  busy_n++;
            if (obs_q[i][8])  begin done_n++; done_at = i; end
        end
        // Start cycle is cycle 1, so done lands at trace index 50 (cycle 51).
        checks++;
        if (done_n !== 1 || done_at !== 50) begin
            errors++;
            $display("FAIL full_done got %0d pulses at %0d want 1 at 50", done_n, done_at);
        end
        checks++;
        if (wps_n !== 32) begin errors++; $display("FAIL full_wps got %0d want 32", wps_n); end
        checks++;
        if (av_n !== 48) begin errors++; $display("FAIL full_arr_valid got %0d want 48", av_n); end
        checks++;
        if (busy_n !== 50) begin errors++; $display("FAIL full_busy got %0d want 50", busy_n); end
        collect_rcv();
        checks++;
        if (rcv_q.size() !== 48) begin
            errors++;
            $display("FAIL full_rcv_count got %0d want 48", rcv_q.size());
        end else begin
            for (int i = 0; i < 48; i++) begin
                checks++;
                if (rcv_q[i] !== 8'((i < 32) ? i : i - 32)) begin
                    errors++;
                    $display("FAIL full_data idx %0d got %0d want %0d", i, rcv_q[i], (i < 32) ? i : i - 32);
                end
            end
        end
    endtask

    task automatic test_stall();
        int stall_left;
        bit stalled;
        int guard;
        int wps_n;
        logic sv;
        clear_trace();
        stall_left = 0; stalled = 0; guard = 0;
        drive_cycle(1'b1, 1'b1, 8'($urandom));
        while (m_phase != PH_IDLE && guard < 500) begin
            sv = 1'b1;
            if (m_phase == PH_W && m_cnt == 11 && !stalled) begin
                stall_left = 3;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                sv = 1'b0;
                stall_left--;
            end
            drive_cycle(1'b0, sv, 8'($urandom));
            guard++;
        end
        checks++;
        if (guard >= 500) begin errors++; $display("FAIL stall_timeout got %0d cycles want <500", guard); end
        drive_cycle(1'b0, 1'b0, 8'h00);
        wps_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_trace cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][12]) wps_n++;
        end
        checks++;
        if (wps_n !== 35) begin errors++; $display("FAIL stall_wps got %0d want 35", wps_n); end
        collect_rcv();
        checks++;
        if (rcv_q.size() !== 48 || rcv_q != sent_q) begin
            errors++;
            $display("FAIL stall_order got %0d words want 48 in send order", rcv_q.size());
        end
    endtask

    task automatic test_restart_ignored();
        int guard;
        int done_n;
        logic st;
        clear_trace();
        guard = 0;
        drive_cycle(1'b1, 1'b1, 8'($urandom));
        while (m_phase != PH_IDLE && guard < 500) begin
            st = (m_phase == PH_P || m_phase == PH_DONE) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_cycle(st, 1'($urandom_range(0, 3) != 0), 8'($urandom));
            guard++;
        end
        checks++;
        if (guard >= 500) begin errors++; $display("FAIL restart_timeout got %0d cycles want <500", guard); end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 8'($urandom));
        done_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_trace cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][8]) done_n++;
        end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_n); end
        checks++;
        if (sent_q.size() !== 48) begin errors++; $display("FAIL restart_words got %0d want 48", sent_q.size()); end
    endtask

    task automatic test_reset_mid();
        int guard;
        int done_n;
        clear_trace();
        guard = 0;
        drive_cycle(1'b1, 1'b1, 8'($urandom));
        while (!(m_phase == PH_W && m_cnt == 20) && guard < 200) begin
            drive_cycle(1'b0, 1'b1, 8'($urandom));
            guard++;
        end
        done_n = 0;
        foreach (obs_q[i]) if (obs_q[i][8]) done_n++;
        checks++;
        if (done_n !== 0 || guard >= 200) begin
            errors++;
            $display("FAIL rstmid_pre got done=%0d cycles=%0d want done=0 cycles<200", done_n, guard);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus_a.w_ps, bus_a.src_ready, bus_a.arr_valid, bus_a.busy, bus_a.done, bus_a.arr_data} !== 13'h0) begin
            errors++;
            $display("FAIL rstmid_async got %h want 0", {bus_a.w_ps, bus_a.src_ready, bus_a.arr_valid, bus_a.busy, bus_a.done, bus_a.arr_data});
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.arr_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_hold got %b want 000", {bus_a.busy, bus_a.done, bus_a.arr_valid});
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        clear_trace();
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 8'($urandom));
        guard = 0;
        drive_cycle(1'b1, 1'b1, 8'($urandom));
        while (m_phase != PH_IDLE && guard < 500) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 4) != 0), 8'($urandom));
            guard++;
        end
        drive_cycle(1'b0, 1'b0, 8'h00);
        done_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_trace cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][8]) done_n++;
        end
        collect_rcv();
        checks++;
        if (done_n !== 1 || rcv_q.size() !== 48 || rcv_q != sent_q) begin
            errors++;
            $display("FAIL rstmid_resequence got done=%0d words=%0d want done=1 words=48 in order", done_n, rcv_q.size());
        end
    endtask

    // NW=1/NP=1 instance: start cycle, LOAD_W, GAP, LOAD_P, DONE, then idle.
    task automatic test_small();
        logic [7:0] d0;
        logic [7:0] d1;
        logic [4:0] obs;
        logic [4:0] exp_t[8];
        int busy_n;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        // {w_ps, src_ready, arr_valid, busy, done} per cycle
        exp_t[0] = 5'b00000;
        exp_t[1] = 5'b11010;
        exp_t[2] = 5'b00110;
        exp_t[3] = 5'b01010;
        exp_t[4] = 5'b00111;
        exp_t[5] = 5'b00000;
        exp_t[6] = 5'b00000;
        exp_t[7] = 5'b00000;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            obs = {bus_b.w_ps, bus_b.src_ready, bus_b.arr_valid, bus_b.busy, bus_b.done};
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL small_flags cyc %0d got %b want %b", i, obs, exp_t[i]);
            end
            if (i == 2 || i == 4) begin
                checks++;
                if (bus_b.arr_data !== ((i == 2) ? d0 : d1)) begin
                    errors++;
                    $display("FAIL small_data cyc %0d got %h want %h", i, bus_b.arr_data, (i == 2) ? d0 : d1);
                end
            end
            if (bus_b.busy) busy_n++;
            bus_b.start     = (i == 0);
            bus_b.src_valid = 1'b1;
            bus_b.src_data  = (i < 2) ? d0 : d1;
            @(posedge clk);
            #1;
        end
        bus_b.src_valid = 1'b0;
        checks++;
        if (busy_n !== 4) begin errors++; $display("FAIL small_busy got %0d want 4", busy_n); end
    endtask

    task automatic test_random();
        int guard;
        int done_n;
        clear_trace();
        guard = 0;
        for (int s = 0; s < 4; s++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            while (m_phase != PH_IDLE && guard < 2000) begin
                drive_cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) < 7), 8'($urandom));
                guard++;
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) drive_cycle(1'b0, 1'b1, 8'($urandom));
        end
        drive_cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (guard >= 2000) begin errors++; $display("FAIL random_timeout got %0d cycles want <2000", guard); end
        done_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_trace cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][8]) done_n++;
        end
        collect_rcv();
        checks++;
        if (done_n !== 4 || rcv_q.size() !== 192 || rcv_q != sent_q) begin
            errors++;
            $display("FAIL random_stream got done=%0d words=%0d want done=4 words=192 in order", done_n, rcv_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_small();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
